// File: rtl/demux_serial4.sv
// Serial-to-parallel demultiplexer: one bit per cycle is steered to one of four channels,
// each assembling an LSB-first word. Parity outputs exist only with DEMUX_PARIDADE_EN.
module demux_serial4 #(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               m,
    input  logic               valido,
    input  logic               din,
    input  logic [1:0]         canal,
    input  logic [3:0]         ack,
    output logic [3:0]         sel,
    output logic [LARGURA-1:0] dado_a,
    output logic [LARGURA-1:0] dado_b,
    output logic [LARGURA-1:0] dado_c,
    output logic [LARGURA-1:0] dado_d,
    output logic [3:0]         pronto,
    output logic [3:0]         erro,
    output logic [3:0]         paridade
);

    localparam int unsigned     CntW    = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(LARGURA - 1);

    // The top bit is never stored: it arrives on the completing edge and goes straight to dado.
    logic [LARGURA-2:0] r_shift [4];
    logic [CntW-1:0]    r_cnt   [4];
    logic [LARGURA-1:0] r_dado  [4];
    logic [3:0]         r_sel;
    logic [3:0]         r_pronto;
    logic [3:0]         r_erro;

    logic               w_req;
    logic               w_acc;
    logic               w_drop;
    logic               w_last;
    logic [3:0]         w_hot;
    logic [LARGURA-1:0] w_word;

    // Acceptance uses the pre-edge pronto, so a same-edge ack does not open the channel.
    assign w_req  = m & valido;
    assign w_acc  = w_req & ~r_pronto[canal];
    assign w_drop = w_req & r_pronto[canal];
    assign w_last = (r_cnt[canal] == LastCnt);
    assign w_hot  = 4'b0001 << canal;
    assign w_word = {din, r_shift[canal]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel    <= '0;
            r_pronto <= '0;
            r_erro   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_shift[i] <= '0;
                r_cnt[i]   <= '0;
                r_dado[i]  <= '0;
            end
        end else begin
            r_sel    <= w_acc ? w_hot : 4'b0000;
            r_pronto <= r_pronto & ~ack;
            if (w_drop) begin
                r_erro[canal] <= 1'b1;
            end
            if (w_acc) begin
                if (w_last) begin
                    r_cnt[canal]    <= '0;
                    r_dado[canal]   <= w_word;
                    r_pronto[canal] <= 1'b1;
                end else begin
                    r_shift[canal][r_cnt[canal]] <= din;
                    r_cnt[canal]                 <= r_cnt[canal] + 1'b1;
                end
            end
        end
    end

`ifdef DEMUX_PARIDADE_EN
    logic [3:0] r_paridade;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_paridade <= '0;
        end else if (w_acc && w_last) begin
            r_paridade[canal] <= ^w_word;
        end
    end

    assign paridade = r_paridade;
`else
    assign paridade = 4'b0000;
`endif

    assign sel    = r_sel;
    assign pronto = r_pronto;
    assign erro   = r_erro;
    assign dado_a = r_dado[0];
    assign dado_b = r_dado[1];
    assign dado_c = r_dado[2];
    assign dado_d = r_dado[3];

endmodule

// File: tb/tb_demux_serial4.sv
// Self-checking bench for demux_serial4: vector table, directed corner sequences and
// randomized traffic against a word-level reference model.
module tb_demux_serial4;

    localparam int unsigned W = 8;
`ifdef DEMUX_PARIDADE_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         m = 1'b0;
    logic         valido = 1'b0;
    logic         din = 1'b0;
    logic [1:0]   canal = 2'd0;
    logic [3:0]   ack = 4'h0;
    logic [3:0]   sel;
    logic [W-1:0] dado_a;
    logic [W-1:0] dado_b;
    logic [W-1:0] dado_c;
    logic [W-1:0] dado_d;
    logic [3:0]   pronto;
    logic [3:0]   erro;
    logic [3:0]   paridade;
    logic [W-1:0] dado_w [4];

    assign dado_w[0] = dado_a;
    assign dado_w[1] = dado_b;
    assign dado_w[2] = dado_c;
    assign dado_w[3] = dado_d;

    demux_serial4 #(.LARGURA(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .m        (m),
        .valido   (valido),
        .din      (din),
        .canal    (canal),
        .ack      (ack),
        .sel      (sel),
        .dado_a   (dado_a),
        .dado_b   (dado_b),
        .dado_c   (dado_c),
        .dado_d   (dado_d),
        .pronto   (pronto),
        .erro     (erro),
        .paridade (paridade)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-channel bit count and accumulated value.
    int           mcnt  [4];
    logic [W-1:0] mpart [4];
    logic [W-1:0] mdado [4];
    logic [3:0]   mp   = 4'h0;
    logic [3:0]   me   = 4'h0;
    logic [3:0]   msel = 4'h0;
    logic [3:0]   mpar = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic mm, input logic vv, input logic dd,
                                input logic [1:0] cc, input logic [3:0] aa);
        logic [3:0] p_old;
        int         ch;
        p_old = mp;
        ch    = int'(cc);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mcnt[i]  = 0;
                mpart[i] = '0;
                mdado[i] = '0;
            end
            mp   = 4'h0;
            me   = 4'h0;
            msel = 4'h0;
            mpar = 4'h0;
        end else begin
            msel = 4'h0;
            mp   = p_old & ~aa;
            if (mm && vv) begin
                if (p_old[ch]) begin
                    me[ch] = 1'b1;
                end else begin
                    msel[ch]  = 1'b1;
                    mpart[ch] = mpart[ch] + (W'(dd) << mcnt[ch]);
                    mcnt[ch]  = mcnt[ch] + 1;
                    if (mcnt[ch] == W) begin
                        mdado[ch] = mpart[ch];
                        mpart[ch] = '0;
                        mcnt[ch]  = 0;
                        mp[ch]    = 1'b1;
                        if (ParEn) mpar[ch] = ($countones(mdado[ch]) % 2) == 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic mm, input logic vv, input logic dd,
                        input logic [1:0] cc, input logic [3:0] aa);
        reset  = rst;
        m      = mm;
        valido = vv;
        din    = dd;
        canal  = cc;
        ack    = aa;
        @(posedge clock);
        model_update(rst, mm, vv, dd, cc, aa);
        #1;
        check("sel", 32'(sel), 32'(msel));
        check("pronto", 32'(pronto), 32'(mp));
        check("erro", 32'(erro), 32'(me));
        check("paridade", 32'(paridade), 32'(mpar));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dado[%0d]", i), 32'(dado_w[i]), 32'(mdado[i]));
        end
    endtask

    task automatic send_word(input logic [1:0] ch, input logic [W-1:0] word);
        for (int k = 0; k < int'(W); k++) begin
            step(1'b0, 1'b1, 1'b1, word[k], ch, 4'h0);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    endtask

    typedef struct packed {
        logic       rst;
        logic       m;
        logic       v;
        logic       d;
        logic [1:0] c;
        logic [3:0] ack;
        logic [3:0] sel;
        logic [3:0] pronto;
        logic [3:0] erro;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] stream;

    initial begin
        for (int i = 0; i < 4; i++) begin
            mcnt[i]  = 0;
            mpart[i] = '0;
            mdado[i] = '0;
        end

        // Vector table: channel 2 receives 8'h4D, then overrun, ack and a disabled cycle.
        stream = 8'h4D;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int k = 0; k < 8; k++) begin
            tbl[1+k] = '{1'b0, 1'b1, 1'b1, stream[k], 2'd2, 4'h0, 4'b0100,
                         (k == 7) ? 4'b0100 : 4'b0000, 4'h0};
        end
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'h0, 4'b0000, 4'b0100, 4'b0100};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'h0, 4'b0000, 4'b0000, 4'b0100};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].m, tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].ack);
            check($sformatf("tbl%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
            check($sformatf("tbl%0d.pronto", i), 32'(pronto), 32'(tbl[i].pronto));
            check($sformatf("tbl%0d.erro", i), 32'(erro), 32'(tbl[i].erro));
            if (i == 8) check("tbl.dado_c", 32'(dado_c), 32'h4D);
        end
        check("dado_c_held", 32'(dado_c), 32'h4D);

        // Interleaved channels 0 and 3 finish on consecutive edges.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        stream = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] w3;
            w3 = 8'h3C;
            step(1'b0, 1'b1, 1'b1, stream[k], 2'd0, 4'h0);
            step(1'b0, 1'b1, 1'b1, w3[k], 2'd3, 4'h0);
        end
        check("ilv.pronto", 32'(pronto), 32'b1001);
        check("ilv.dado_a", 32'(dado_a), 32'hA5);
        check("ilv.dado_d", 32'(dado_d), 32'h3C);
        check("ilv.erro", 32'(erro), 32'h0);

        // Overrun on a full channel, then ack leaves erro sticky.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        send_word(2'd1, 8'h5A);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h0);
        check("ovr.erro", 32'(erro), 32'b0010);
        check("ovr.dado_b", 32'(dado_b), 32'h5A);
        check("ovr.sel", 32'(sel), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010);
        check("ack.pronto", 32'(pronto), 32'h0);
        check("ack.erro", 32'(erro), 32'b0010);
        check("ack.dado_b", 32'(dado_b), 32'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001);
        check("ack_idle.pronto", 32'(pronto), 32'h0);

        // Ack and a new bit on the same edge: bit dropped, erro set.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        send_word(2'd1, 8'hC3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010);
        check("ackbit.pronto", 32'(pronto), 32'h0);
        check("ackbit.erro", 32'(erro), 32'b0010);
        check("ackbit.sel", 32'(sel), 32'h0);
        send_word(2'd1, 8'h81);
        check("ackbit.dado_b", 32'(dado_b), 32'h81);

        // Reset mid-word leaves no residue.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        send_word(2'd0, 8'hFF);
        check("rst.dado_a", 32'(dado_a), 32'hFF);
        check("rst.pronto", 32'(pronto), 32'b0001);

        // Reset beats m/valido/ack on the same edge.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'hF);
        check("rstpri.pronto", 32'(pronto), 32'h0);
        check("rstpri.erro", 32'(erro), 32'h0);
        check("rstpri.sel", 32'(sel), 32'h0);
        check("rstpri.dado_a", 32'(dado_a), 32'h0);

        // Partial word survives m=0 with valido=1.
        stream = 8'h96;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, stream[k], 2'd2, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'h0);
            check("m0.sel", 32'(sel), 32'h0);
            check("m0.pronto", 32'(pronto), 32'h0);
        end
        for (int k = 3; k < 8; k++) step(1'b0, 1'b1, 1'b1, stream[k], 2'd2, 4'h0);
        check("m0.dado_c", 32'(dado_c), 32'h96);

        // Parity of 8'h07 is odd.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        send_word(2'd3, 8'h07);
        check("par.paridade", 32'(paridade), ParEn ? 32'b1000 : 32'h0);

        // Randomized traffic against the model.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] a;
            a = 4'h0;
            for (int i = 0; i < 4; i++) a[i] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), a);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
